text_ram_port_arbiter: RTL and testbench

// Shares port A of the dual-port text RAM (clk100M domain) between two masters: the VT100

---
 rtl/text_ram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_text_ram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_port_arbiter.sv
// rtl/text_ram_port_arbiter.sv - two-master round-robin arbiter with burst lock for text RAM port A
module text_ram_port_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              lock0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              lock1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_wren_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } state_t;

    state_t             state_q;
    logic               last_owner_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic [ADDR_W-1:0]  ram_address_q;
    logic [DATA_W-1:0]  ram_data_q;
    logic               ram_wren_q;
    logic [RD_LATENCY:0] tag_vld_q;
    logic [RD_LATENCY:0] tag_own_q;

    logic               gnt0_d;
    logic               gnt1_d;
    logic               gnt_any;
    logic               sel;
    logic               sel_we;
    logic               sel_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Grant is combinational so a requester learns acceptance in the same cycle.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (req0_i && req1_i) begin
                        gnt0_d = last_owner_q;
                        gnt1_d = ~last_owner_q;
                    end else begin
                        gnt0_d = req0_i;
                        gnt1_d = req1_i;
                    end
                end
                LOCKED0: gnt0_d = req0_i;
                LOCKED1: gnt1_d = req1_i;
                default: ;
            endcase
        end
    end

    assign gnt_any   = gnt0_d | gnt1_d;
    assign sel       = gnt1_d;
    assign sel_we    = sel ? we1_i    : we0_i;
    assign sel_lock  = sel ? lock1_i  : lock0_i;
    assign sel_addr  = sel ? addr1_i  : addr0_i;
    assign sel_wdata = sel ? wdata1_i : wdata0_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b1;
            idle_cnt_q    <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            tag_vld_q     <= '0;
            tag_own_q     <= '0;
        end else begin
            ram_wren_q <= 1'b0;
            if (gnt_any) begin
                last_owner_q  <= sel;
                ram_address_q <= sel_addr;
                ram_data_q    <= sel_wdata;
                ram_wren_q    <= sel_we;
                idle_cnt_q    <= '0;
                if (sel_lock) begin
                    state_q <= sel ? LOCKED1 : LOCKED0;
                end else begin
                    state_q <= IDLE;
                end
            end else if (state_q != IDLE) begin
                // No grant while locked means the owner is not requesting.
                if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_q    <= IDLE;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                end
            end
            tag_vld_q <= {tag_vld_q[RD_LATENCY-1:0], gnt_any & ~sel_we};
            tag_own_q <= {tag_own_q[RD_LATENCY-1:0], sel};
        end
    end

    assign gnt0_o        = gnt0_d;
    assign gnt1_o        = gnt1_d;
    assign ram_address_o = ram_address_q;
    assign ram_data_o    = ram_data_q;
    assign ram_wren_o    = ram_wren_q;
    assign rvalid0_o     = tag_vld_q[RD_LATENCY] & ~tag_own_q[RD_LATENCY];
    assign rvalid1_o     = tag_vld_q[RD_LATENCY] &  tag_own_q[RD_LATENCY];
    assign rdata0_o      = ram_q_i;
    assign rdata1_o      = ram_q_i;

endmodule

// File: tb/tb_text_ram_port_arbiter.sv
// tb/tb_text_ram_port_arbiter.sv - scoreboard bench for text_ram_port_arbiter with RAM model
module tb_text_ram_port_arbiter;

    localparam int RD_LAT = 2;
    localparam int LT     = 64;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        lock;
        int          gap;
    } cmd_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        req_a[2];
    logic        we_a[2];
    logic        lock_a[2];
    logic [11:0] addr_a[2];
    logic [31:0] wdata_a[2];
    logic gnt0, gnt1, rvalid0, rvalid1, ram_wren;
    logic [31:0] rdata0, rdata1, ram_data, ram_q, rd1;
    logic [11:0] ram_address;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t cur[2];
    bit   active[2];
    bit   granted[2];
    int   gap_left[2];

    rd_t sb[$];
    logic [31:0] model_mem[int];
    int lock_owner = -1;
    int idle = 0;
    int last = 1;
    logic        exp_wren = 1'b0;
    logic [11:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    int gcount[2];
    int first_gnt[2];
    int last_gnt[2];
    int rvcnt[2];

    logic [31:0] mem[4096];
    bit          wr_flag[4096];

    text_ram_port_arbiter #(
        .ADDR_W(12), .DATA_W(32), .RD_LATENCY(RD_LAT), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req_a[0]), .we0_i(we_a[0]), .addr0_i(addr_a[0]), .wdata0_i(wdata_a[0]), .lock0_i(lock_a[0]),
        .req1_i(req_a[1]), .we1_i(we_a[1]), .addr1_i(addr_a[1]), .wdata1_i(wdata_a[1]), .lock1_i(lock_a[1]),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rvalid0_o(rvalid0), .rdata0_o(rdata0), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .ram_address_o(ram_address), .ram_data_o(ram_data), .ram_wren_o(ram_wren),
        .ram_q_i(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return init_val(a);
    endfunction

    // Registered-output RAM, two cycles from address to q, new data on read-after-write.
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address]     <= ram_data;
            wr_flag[ram_address] <= 1'b1;
        end
        rd1   <= ram_wren ? ram_data : (wr_flag[ram_address] ? mem[ram_address] : init_val(ram_address));
        ram_q <= rd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Master drivers: hold each command until granted, optional idle gap first.
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 2; n++) begin
            cmd_t c;
            bit   got;
            got = 1'b0;
            if (granted[n]) begin
                active[n]  = 1'b0;
                granted[n] = 1'b0;
            end
            if (!active[n]) begin
                if (n == 0 && q0.size() > 0) begin c = q0.pop_front(); got = 1'b1; end
                if (n == 1 && q1.size() > 0) begin c = q1.pop_front(); got = 1'b1; end
                if (got) begin
                    cur[n]      = c;
                    active[n]   = 1'b1;
                    gap_left[n] = c.gap;
                end
            end
            if (active[n] && gap_left[n] == 0) begin
                req_a[n]   = 1'b1;
                we_a[n]    = cur[n].we;
                addr_a[n]  = cur[n].addr;
                wdata_a[n] = cur[n].data;
                lock_a[n]  = cur[n].lock;
            end else begin
                req_a[n] = 1'b0;
                if (active[n]) gap_left[n]--;
            end
        end
    end

    // Reference arbitration model and issue-side checks.
    always @(negedge clk) begin
        if (rst_n) begin
            int eg;
            chk("ram_wren", 64'(ram_wren), 64'(exp_wren));
            chk("ram_address", 64'(ram_address), 64'(exp_addr));
            chk("ram_data", 64'(ram_data), 64'(exp_data));
            eg = -1;
            if (lock_owner >= 0) begin
                if (req_a[lock_owner]) eg = lock_owner;
            end else if (req_a[0] && req_a[1]) begin
                eg = 1 - last;
            end else if (req_a[0]) begin
                eg = 0;
            end else if (req_a[1]) begin
                eg = 1;
            end
            chk("gnt", 64'({gnt1, gnt0}), (eg == 0) ? 64'd1 : (eg == 1) ? 64'd2 : 64'd0);
            for (int n = 0; n < 2; n++) begin
                if ((n == 0 && gnt0) || (n == 1 && gnt1)) begin
                    gcount[n]++;
                    if (first_gnt[n] < 0) first_gnt[n] = cyc;
                    last_gnt[n] = cyc;
                end
            end
            exp_wren = 1'b0;
            if (eg >= 0) begin
                last       = eg;
                granted[eg] = 1'b1;
                exp_wren   = we_a[eg];
                exp_addr   = addr_a[eg];
                exp_data   = wdata_a[eg];
                if (we_a[eg]) model_mem[int'(addr_a[eg])] = wdata_a[eg];
                else sb.push_back('{owner: eg, data: model_rd(addr_a[eg]), due: cyc + RD_LAT + 1});
                lock_owner = lock_a[eg] ? eg : -1;
                idle       = 0;
            end else if (lock_owner >= 0) begin
                idle++;
                if (idle == LT) begin
                    lock_owner = -1;
                    idle       = 0;
                end
            end
        end
    end

    // Read-return monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid0) rvcnt[0]++;
            if (rvalid1) rvcnt[1]++;
            if (rvalid0 || rvalid1) begin
                chk("rvalid_both", 64'(rvalid0 & rvalid1), 64'd0);
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 64'({rvalid1, rvalid0}), 64'd0);
                end else begin
                    rd_t e;
                    e = sb.pop_front();
                    chk("rvalid_owner", 64'({rvalid1, rvalid0}), (e.owner == 0) ? 64'd1 : 64'd2);
                    chk("rdata", 64'(rvalid1 ? rdata1 : rdata0), 64'(e.data));
                    chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                rd_t e;
                e = sb.pop_front();
                chk("rvalid_missing", 64'({rvalid1, rvalid0}), (e.owner == 0) ? 64'd1 : 64'd2);
            end
        end
    end

    task automatic mark();
        for (int n = 0; n < 2; n++) begin
            gcount[n] = 0; first_gnt[n] = -1; last_gnt[n] = -1; rvcnt[n] = 0;
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || active[0] || active[1] || sb.size() > 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) chk("wait_idle_timeout", 64'(k), 64'(bound - 1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 64'({gnt1, gnt0}), 64'd0);
        chk({tag, "_rvalid"}, 64'({rvalid1, rvalid0}), 64'd0);
        chk({tag, "_ram"}, {20'd0, ram_address, ram_data}, 64'd0);
        chk({tag, "_wren"}, 64'(ram_wren), 64'd0);
    endtask

    task automatic flush_model();
        q0.delete(); q1.delete(); sb.delete();
        for (int n = 0; n < 2; n++) begin
            active[n] = 1'b0; granted[n] = 1'b0; req_a[n] = 1'b0; gap_left[n] = 0;
        end
        lock_owner = -1; idle = 0; last = 1;
        exp_wren = 1'b0; exp_addr = '0; exp_data = '0;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            req_a[n] = 1'b0; we_a[n] = 1'b0; lock_a[n] = 1'b0; addr_a[n] = '0; wdata_a[n] = '0;
        end
        mark();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // Single read from requester 0.
        mark();
        q0.push_back('{we: 1'b0, addr: 12'h010, data: 32'h0, lock: 1'b0, gap: 0});
        wait_idle(200);
        chk("t1_rvcnt", 64'({rvcnt[1][15:0], rvcnt[0][15:0]}), 64'h0000_0001);

        // Both held without lock: strict alternation.
        mark();
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{we: 1'b0, addr: 12'(i), data: 32'h0, lock: 1'b0, gap: 0});
            q1.push_back('{we: 1'b0, addr: 12'(i + 32), data: 32'h0, lock: 1'b0, gap: 0});
        end
        wait_idle(300);
        chk("t2_gcount", 64'({gcount[1][15:0], gcount[0][15:0]}), 64'h0008_0008);

        // Locked burst of five writes from requester 1.
        mark();
        for (int i = 0; i < 5; i++)
            q1.push_back('{we: 1'b1, addr: 12'h200 + 12'(i), data: 32'hA000 + 32'(i), lock: (i < 4), gap: 0});
        q0.push_back('{we: 1'b0, addr: 12'h200, data: 32'h0, lock: 1'b0, gap: 1});
        q0.push_back('{we: 1'b0, addr: 12'h204, data: 32'h0, lock: 1'b0, gap: 0});
        wait_idle(300);
        chk("t3_burst_len", 64'(last_gnt[1] - first_gnt[1]), 64'd4);
        chk("t3_handover", 64'(first_gnt[0] - last_gnt[1]), 64'd1);

        // Lock held then abandoned: released by timeout.
        mark();
        q1.push_back('{we: 1'b1, addr: 12'h300, data: 32'h1234, lock: 1'b1, gap: 0});
        q0.push_back('{we: 1'b0, addr: 12'h300, data: 32'h0, lock: 1'b0, gap: 1});
        wait_idle(400);
        chk("t4_timeout", 64'(first_gnt[0] - first_gnt[1]), 64'(LT + 1));

        // Write then immediate read of the same word by the other requester.
        mark();
        q0.push_back('{we: 1'b1, addr: 12'h123, data: 32'hDEADBEEF, lock: 1'b0, gap: 0});
        q1.push_back('{we: 1'b0, addr: 12'h123, data: 32'h0, lock: 1'b0, gap: 1});
        wait_idle(200);
        chk("t5_rvcnt", 64'({rvcnt[1][15:0], rvcnt[0][15:0]}), 64'h0001_0000);

        // Reset with two reads in flight.
        q0.push_back('{we: 1'b0, addr: 12'h040, data: 32'h0, lock: 1'b0, gap: 0});
        q1.push_back('{we: 1'b0, addr: 12'h041, data: 32'h0, lock: 1'b0, gap: 0});
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        flush_model();
        mark();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_rvalid", 64'({rvcnt[1][15:0], rvcnt[0][15:0]}), 64'h0);

        // Randomised traffic, small address range to hit read-after-write.
        for (int i = 0; i < 120; i++) begin
            for (int n = 0; n < 2; n++) begin
                cmd_t c;
                c.we   = 1'($urandom_range(0, 1));
                c.addr = 12'($urandom_range(0, 15));
                c.data = $urandom;
                c.lock = ($urandom_range(0, 3) == 0);
                c.gap  = ($urandom_range(0, 24) == 0) ? 70 : $urandom_range(0, 2);
                if (n == 0) q0.push_back(c); else q1.push_back(c);
            end
        end
        wait_idle(30000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
